// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// in_ready comes straight from the skid-valid flop, so back-pressure never forms a combinational path.
module pipe_stage_skid #(
  parameter int CTRL_W              = 16,
  parameter int DATA_W              = 128,
  parameter bit CLEAR_DATA_ON_FLUSH = 1'b0,
  parameter int CNT_W               = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  // Encoding is {main valid, skid valid}; BAD (skid without main) is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    BAD   = 2'b01,
    HALF  = 2'b10,
    FULL  = 2'b11
  } state_t;

  state_t              state, state_nxt;
  logic [CTRL_W-1:0]   m_ctrl, m_ctrl_nxt, s_ctrl, s_ctrl_nxt;
  logic [DATA_W-1:0]   m_data, m_data_nxt, s_data, s_data_nxt;
  logic                accept, take;

  assign in_ready  = ~state[0];
  assign out_valid = state[1];
  assign out_ctrl  = m_ctrl;
  assign out_data  = m_data;
  assign occupancy = {1'b0, state[1]} + {1'b0, state[0]};

  assign accept = in_valid & in_ready;
  assign take   = out_valid & out_ready;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt  = state;
    m_ctrl_nxt = m_ctrl;
    m_data_nxt = m_data;
    s_ctrl_nxt = s_ctrl;
    s_data_nxt = s_data;
    if (flush) begin
      state_nxt  = EMPTY;
      m_ctrl_nxt = '0;
      s_ctrl_nxt = '0;
      if (CLEAR_DATA_ON_FLUSH) begin
        m_data_nxt = '0;
        s_data_nxt = '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_nxt  = HALF;
            m_ctrl_nxt = in_ctrl;
            m_data_nxt = in_data;
          end
        end
        HALF: begin
          if (accept && take) begin
            m_ctrl_nxt = in_ctrl;
            m_data_nxt = in_data;
          end else if (accept) begin
            state_nxt  = FULL;
            s_ctrl_nxt = in_ctrl;
            s_data_nxt = in_data;
          end else if (take) begin
            // Main data is left in place; only ctrl is cleared to make the bubble a NOP.
            state_nxt  = EMPTY;
            m_ctrl_nxt = '0;
          end
        end
        FULL: begin
          if (take) begin
            state_nxt  = HALF;
            m_ctrl_nxt = s_ctrl;
            m_data_nxt = s_data;
            s_ctrl_nxt = '0;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: the payload registers are reset too, so out_data reads zero straight after reset.
      state     <= EMPTY;
      m_ctrl    <= '0;
      m_data    <= '0;
      s_ctrl    <= '0;
      s_data    <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      state  <= state_nxt;
      m_ctrl <= m_ctrl_nxt;
      m_data <= m_data_nxt;
      s_ctrl <= s_ctrl_nxt;
      s_data <= s_data_nxt;
      if (out_valid && !out_ready && stall_cnt != '1) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && flush_cnt != '1)                   flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

  a_no_bad_state : assert property (@(posedge clk) disable iff (reset) state != BAD);

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
Generalised inter-stage pipeline register for the pipelined CPU. It replaces the fixed-field, always-advancing stage registers with a parametrised control and data payload, a valid/ready handshake, and a 2-entry skid buffer. in_ready is driven straight from a flop, so back-pressure never forms a combinational path between stages. Flush inserts an all-zero-control bubble, and saturating stall/flush counters feed performance analysis.

Parameters:
CTRL_W, 16, width of control bundle (Branch, RegWr, MemRead, ALUOp, ...); all-zero value = NOP.
DATA_W, 128, width of datapath bundle (PC, operands, immediate, register indices, ...).
CLEAR_DATA_ON_FLUSH, 0, 1 = flush also zeroes data in both entries; 0 = data entries hold.
CNT_W, 16, width of the stall and flush performance counters.

Ports:
clk  in  1  clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
flush  in  1  synchronous squash of all held entries.
in_valid  in  1  upstream has a valid bundle.
in_ready  out  1  stage can accept; equals NOT skid_valid, driven from flop.
in_ctrl  in  CTRL_W  upstream control bundle.
in_data  in  DATA_W  upstream data bundle.
out_valid  out  1  main entry valid.
out_ready  in  1  downstream accepts this cycle.
out_ctrl  out  CTRL_W  main entry control; 0 whenever out_valid=0.
out_data  out  DATA_W  main entry data.
occupancy  out  2  number of valid entries (0..2).
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0; saturating.
flush_cnt  out  CNT_W  cycles with flush=1 (reset excluded); saturating.

Behaviour:
- Storage: main entry M (valid, ctrl, data) drives the outputs. Skid entry S (valid, ctrl, data) is internal.
- accept = in_valid & in_ready. take = out_valid & out_ready.
- Reset (priority 1): M/S valid=0; all ctrl and data =0; counters =0.
  - Outputs after reset: out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0, flush_cnt=0.
- Flush (priority 2):
  - M/S valid=0; M/S ctrl=0; data zeroed only if CLEAR_DATA_ON_FLUSH=1.
  - A same-cycle accept is discarded, and a same-cycle take is still consumed by downstream.
  - flush_cnt increments (saturating). Next cycle: in_ready=1, occupancy=0.
- States, decoded from (M.valid, S.valid):
  - EMPTY:
    - accept -> M<=in, go to HALF. Latency is 1 cycle from accept to out_valid.
  - HALF:
    - accept & take -> M<=in, stay HALF.
    - accept & !take -> S<=in, go to FULL.
    - !accept & take -> M.valid=0, M.ctrl=0, M.data holds, go to EMPTY.
    - otherwise -> hold.
  - FULL: in_ready=0, so no accept is possible.
    - take -> M<=S, S.valid=0, S.ctrl=0, go to HALF.
    - otherwise -> hold.
- Illegal state (M invalid, S valid) is unreachable. Assert that it never occurs.
- Ordering: bundles leave in accept order; none is duplicated or lost except by flush.
- Held outputs: out_ctrl and out_data stay stable while out_valid=1 and out_ready=0.
- stall_cnt: +1 on each cycle with out_valid & !out_ready; it saturates at all-ones and is not cleared by flush.
- flush_cnt: saturates at all-ones.
- occupancy = M.valid + S.valid, derived from registered state.
- in_valid with in_ready=0 has no effect; upstream must hold its bundle.

Test Plan:
1. Reset mid-traffic: with both entries full, assert reset 1 cycle -> next cycle out_valid=0, out_ctrl=0, out_data=0, in_ready=1, occupancy=0, both counters 0.
2. Streaming: out_ready=1, feed bundles data=1..8 back-to-back -> out_data=1..8 in order, each 1 cycle after accept, in_ready stays 1, stall_cnt=0.
3. Back-pressure/skid: feed A=0x11, B=0x22, C=0x33 with out_ready=0 -> A in M, B in S, in_ready=0 and C held upstream, occupancy=2, stall_cnt increments each cycle. Raise out_ready -> outputs A, B, C in order, no loss.
4. Flush while FULL, with in_valid=1 the same cycle -> next cycle out_valid=0, out_ctrl=0, occupancy=0, flush_cnt=1, pending input not captured. Check data held for CLEAR_DATA_ON_FLUSH=0 and zeroed for 1.
5. Simultaneous accept+take in HALF, repeated 20 cycles, with flush on cycle 10 -> occupancy ends ≤1, ordering correct before and after the flush, flush_cnt=1.
6. Counter saturation, CNT_W=4: hold out_valid=1, out_ready=0 for 20 cycles -> stall_cnt=15 and stays 15.
